// File: rtl/a2d_scan_pkg.sv
// Shared types and widths for the A2D round-robin scan scheduler.
// Keeps the FSM encoding and bank geometry in one place.
package a2d_scan_pkg;
   localparam int CHNL_W   = 3;
   localparam int RES_W    = 12;
   localparam int MAX_CHNL = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      COMMIT = 2'd3
   } state_t;
endpackage

// File: rtl/a2d_scan_tmr.sv
// Free-running auto-scan period counter.
// Pulses tick_o on the last count of each period; held at 0 while disabled.
module a2d_scan_tmr #(
   parameter logic [19:0] PERIOD = 20'd1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);
   logic [19:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == PERIOD - 20'd1);

   always_comb begin
      cnt_d = cnt_q + 20'd1;
      if (!en_i || tick_o) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/a2d_scan_ctrl.sv
// Round-robin A2D scan scheduler: issues one conversion per mapped channel,
// gathers results in a shadow bank and commits the whole scan atomically.
import a2d_scan_pkg::*;

module a2d_scan_ctrl #(
   parameter int          NUM_CHNL = 4,
   parameter logic [23:0] CHNL_MAP = 24'h00_0000,
   parameter logic [19:0] PERIOD   = 20'd1000000,
   parameter logic [15:0] TMO      = 16'd4096,
   parameter logic        INVERT   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              trig,
   input  logic              clr_err,
   output logic              strt_cnv,
   output logic [CHNL_W-1:0] chnnl,
   input  logic              cnv_cmplt,
   input  logic [RES_W-1:0]  res,
   input  logic [2:0]        rd_sel,
   output logic [RES_W-1:0]  rd_data,
   output logic              scan_done,
   output logic              busy,
   output logic              ovr,
   output logic              tmo_err
);
   localparam logic [3:0]        NUM_C = 4'(NUM_CHNL);
   localparam logic [CHNL_W-1:0] LAST  = CHNL_W'(NUM_CHNL - 1);

   state_t            state_q, state_d;
   logic [2:0]        slot_q, slot_d;
   logic [15:0]       tmo_q, tmo_d;
   logic              ovr_q, ovr_d;
   logic              terr_q, terr_d;
   logic              tick, abort;
   logic [RES_W-1:0]  shdw_q [MAX_CHNL];
   logic [RES_W-1:0]  bank_q [MAX_CHNL];
   logic [CHNL_W-1:0] map [MAX_CHNL];

   for (genvar i = 0; i < MAX_CHNL; i++) begin : g_map
      assign map[i] = CHNL_MAP[CHNL_W*i +: CHNL_W];
   end

   a2d_scan_tmr #(.PERIOD(PERIOD)) u_tmr (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .tick_o (tick)
   );

   assign abort = (state_q == WAIT) && !cnv_cmplt
               && (tmo_q == TMO - 16'd1);

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         IDLE: begin
            if (trig || tick) begin
               state_d = ISSUE;
               slot_d  = '0;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            tmo_d   = '0;
         end
         WAIT: begin
            if (cnv_cmplt) begin
               if (slot_q == LAST) begin
                  state_d = COMMIT;
               end else begin
                  slot_d  = slot_q + 3'd1;
                  state_d = ISSUE;
               end
            end else if (abort) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // a fresh error event outranks a simultaneous clear
   assign ovr_d  = (trig && state_q != IDLE) || (ovr_q && !clr_err);
   assign terr_d = abort || (terr_q && !clr_err);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         slot_q  <= '0;
         tmo_q   <= '0;
         ovr_q   <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         tmo_q   <= tmo_d;
         ovr_q   <= ovr_d;
         terr_q  <= terr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_CHNL; i++) begin
            shdw_q[i] <= '0;
            bank_q[i] <= '0;
         end
      end else begin
         if (state_q == WAIT && cnv_cmplt)
            shdw_q[slot_q] <= INVERT ? ~res : res;
         if (state_q == COMMIT)
            for (int i = 0; i < MAX_CHNL; i++)
               bank_q[i] <= shdw_q[i];
      end
   end

   assign strt_cnv  = (state_q == ISSUE);
   assign scan_done = (state_q == COMMIT);
   assign busy      = (state_q != IDLE);
   assign chnnl     = map[slot_q];
   assign ovr       = ovr_q;
   assign tmo_err   = terr_q;
   assign rd_data   = ({1'b0, rd_sel} < NUM_C) ? bank_q[rd_sel] : '0;
endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Scoreboard bench for a2d_scan_ctrl: expected channel order is queued by the
// stimulus and popped by a monitor on every strt_cnv.
module tb_a2d_scan_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en, trig, clr_err, cnv_cmplt;
   logic [11:0] res;
   logic [2:0]  rd_sel;
   logic        strt_cnv, scan_done, busy, ovr, tmo_err;
   logic [2:0]  chnnl;
   logic [11:0] rd_data;

   logic        en1, trig1, cnv1;
   logic [11:0] res1;
   logic [2:0]  rd_sel1;
   logic        strt1, done1, busy1, ovr1, tmo1;
   logic [2:0]  chnnl1;
   logic [11:0] rd_data1;

   a2d_scan_ctrl #(
      .NUM_CHNL(4), .CHNL_MAP(24'h000D08), .PERIOD(20'd50),
      .TMO(16'd40), .INVERT(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .trig(trig), .clr_err(clr_err),
      .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt),
      .res(res), .rd_sel(rd_sel), .rd_data(rd_data),
      .scan_done(scan_done), .busy(busy), .ovr(ovr), .tmo_err(tmo_err)
   );

   a2d_scan_ctrl #(
      .NUM_CHNL(1), .CHNL_MAP(24'h000000), .PERIOD(20'd50),
      .TMO(16'd40), .INVERT(1'b0)
   ) dut1 (
      .clk(clk), .rst(rst), .en(en1), .trig(trig1), .clr_err(clr_err),
      .strt_cnv(strt1), .chnnl(chnnl1), .cnv_cmplt(cnv1),
      .res(res1), .rd_sel(rd_sel1), .rd_data(rd_data1),
      .scan_done(done1), .busy(busy1), .ovr(ovr1), .tmo_err(tmo1)
   );

   int n_chk = 0, n_pass = 0, cyc = 0;
   int done_cnt = 0, done1_cnt = 0;
   int hold_ch = -1, late_cnt = 0, late_seen = 0;
   int m_cnt = 0, m1_cnt = 0, last_cnv = -10, last_strt = 0;
   logic [11:0] base = 12'h100;
   logic [2:0]  m_ch;
   logic        prev_busy = 1'b0;
   int exp_ch[$], exp_ch1[$], starts[$];
   int chs[4] = '{0, 1, 4, 6};

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic fail(string nm);
      n_chk++;
      $display("FAIL %s: event missing or unexpected", nm);
   endtask

   task automatic tick_n(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(string nm, logic [2:0] s, logic [11:0] exp);
      rd_sel = s;
      #1;
      chk(nm, 32'(rd_data), 32'(exp));
   endtask

   task automatic wait_done(int n, int bound);
      int k = 0;
      while (done_cnt < n && k < bound) begin
         tick_n(1);
         k++;
      end
      if (done_cnt < n) fail("done_timeout");
   endtask

   always @(posedge clk) cyc++;

   // A2D model for dut: 3-clk conversion, chnnl must hold until cnv_cmplt
   always @(negedge clk) begin
      cnv_cmplt = 1'b0;
      if (late_cnt != late_seen) begin
         late_seen = late_cnt;
         cnv_cmplt = 1'b1;
         res = 12'h555;
      end else if (m_cnt > 0) begin
         chk("chnnl_hold", 32'(chnnl), 32'(m_ch));
         m_cnt--;
         if (m_cnt == 0) begin
            cnv_cmplt = 1'b1;
            res = base + 12'(m_ch);
            last_cnv = cyc;
         end
      end else if (strt_cnv && int'(chnnl) != hold_ch) begin
         m_ch = chnnl;
         m_cnt = 3;
      end
   end

   always @(negedge clk) begin
      cnv1 = 1'b0;
      if (m1_cnt > 0) begin
         m1_cnt--;
         if (m1_cnt == 0) begin
            cnv1 = 1'b1;
            res1 = 12'hABC;
         end
      end else if (strt1) begin
         m1_cnt = 2;
      end
   end

   // monitor: pops expected channel on each strt_cnv
   always @(negedge clk) begin
      if (strt_cnv) begin
         last_strt = cyc;
         if (exp_ch.size() == 0) fail("strt_unexpected");
         else chk("strt_ch", 32'(chnnl), 32'(exp_ch.pop_front()));
      end
      if (scan_done) begin
         done_cnt++;
         chk("done_lat", 32'(cyc - last_cnv), 32'd1);
      end
      if (busy && !prev_busy) starts.push_back(cyc);
      prev_busy = busy;
      if (strt1) begin
         if (exp_ch1.size() == 0) fail("strt1_unexpected");
         else chk("strt1_ch", 32'(chnnl1), 32'(exp_ch1.pop_front()));
      end
      if (done1) done1_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k, s0, d;
      rst = 1; en = 0; trig = 0; clr_err = 0; rd_sel = 0;
      en1 = 0; trig1 = 0; rd_sel1 = 0; res = 0; res1 = 0;
      tick_n(3);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_strt", 32'(strt_cnv), 0);
      chk("rst_chnnl", 32'(chnnl), 0);
      chk("rst_done", 32'(scan_done), 0);
      chk("rst_ovr", 32'(ovr), 0);
      chk("rst_tmo", 32'(tmo_err), 0);
      chk("rst_rd", 32'(rd_data), 0);
      chk("rst_rd1", 32'(rd_data1), 0);
      rst = 0;
      tick_n(2);

      // 1: single triggered scan
      foreach (chs[i]) exp_ch.push_back(chs[i]);
      trig = 1;
      tick_n(1);
      trig = 0;
      chk("first_strt_lat", 32'(strt_cnv), 1);
      wait_done(1, 200);
      tick_n(1);
      for (int i = 0; i < 4; i++)
         rd_chk("t1_rd", 3'(i), ~(12'h100 + 12'(chs[i])));
      for (int i = 4; i < 8; i++)
         rd_chk("t1_rd_oor", 3'(i), 12'h000);
      chk("t1_q_empty", 32'(exp_ch.size()), 0);

      // 2: periodic scans, dropped trig sets ovr
      tick_n(1);
      s0 = starts.size();
      repeat (3) foreach (chs[i]) exp_ch.push_back(chs[i]);
      en = 1;
      k = 0;
      while (!busy && k < 100) begin tick_n(1); k++; end
      if (!busy) fail("auto_start_timeout");
      tick_n(2);
      trig = 1;
      tick_n(1);
      trig = 0;
      chk("t2_ovr_set", 32'(ovr), 1);
      clr_err = 1;
      tick_n(1);
      clr_err = 0;
      chk("t2_ovr_clr", 32'(ovr), 0);
      wait_done(4, 400);
      en = 0;
      tick_n(60);
      chk("t2_no_extra", 32'(done_cnt), 4);
      chk("t2_starts", 32'(starts.size()), 32'(s0 + 3));
      if (starts.size() == s0 + 3) begin
         chk("t2_period_a", 32'(starts[s0+1] - starts[s0]), 50);
         chk("t2_period_b", 32'(starts[s0+2] - starts[s0+1]), 50);
      end
      chk("t2_q_empty", 32'(exp_ch.size()), 0);

      // 3: slot 1 never completes -> timeout abort
      base = 12'h200;
      hold_ch = 1;
      exp_ch.push_back(0);
      exp_ch.push_back(1);
      trig = 1;
      tick_n(1);
      trig = 0;
      k = 0;
      while (!tmo_err && k < 300) begin tick_n(1); k++; end
      if (!tmo_err) fail("tmo_timeout");
      d = cyc - last_strt;
      chk("t3_tmo_lat", 32'(d >= 40 && d <= 42), 1);
      chk("t3_idle", 32'(busy), 0);
      chk("t3_no_done", 32'(done_cnt), 4);
      rd_chk("t3_keep0", 3'd0, 12'hEFF);
      rd_chk("t3_keep1", 3'd1, 12'hEFE);
      clr_err = 1;
      tick_n(1);
      clr_err = 0;
      chk("t3_tmo_clr", 32'(tmo_err), 0);
      hold_ch = -1;
      chk("t3_q_empty", 32'(exp_ch.size()), 0);

      // 4: reset during WAIT of slot 2, then a late cnv_cmplt
      base = 12'h300;
      hold_ch = 4;
      exp_ch.push_back(0);
      exp_ch.push_back(1);
      exp_ch.push_back(4);
      trig = 1;
      tick_n(1);
      trig = 0;
      k = 0;
      while (exp_ch.size() != 0 && k < 200) begin tick_n(1); k++; end
      if (exp_ch.size() != 0) fail("t4_slot2_timeout");
      tick_n(3);
      chk("t4_busy_pre", 32'(busy), 1);
      rst = 1;
      tick_n(1);
      chk("t4_busy", 32'(busy), 0);
      chk("t4_strt", 32'(strt_cnv), 0);
      for (int i = 0; i < 4; i++) rd_chk("t4_rd_clr", 3'(i), 12'h000);
      rst = 0;
      hold_ch = -1;
      late_cnt++;
      tick_n(6);
      chk("t4_late_busy", 32'(busy), 0);
      chk("t4_late_done", 32'(done_cnt), 4);
      rd_chk("t4_late_rd", 3'd0, 12'h000);

      // 5: dut1, trig coincident with tick
      exp_ch1.push_back(0);
      en1 = 1;
      tick_n(49);
      trig1 = 1;
      tick_n(1);
      trig1 = 0;
      k = 0;
      while (done1_cnt < 1 && k < 100) begin tick_n(1); k++; end
      if (done1_cnt < 1) fail("t5_done_timeout");
      en1 = 0;
      tick_n(60);
      chk("t5_one_scan", 32'(done1_cnt), 1);
      chk("t5_ovr", 32'(ovr1), 0);
      chk("t5_idle", 32'(busy1), 0);
      rd_sel1 = 3'd0;
      #1;
      chk("t5_rd0", 32'(rd_data1), 32'h0ABC);
      rd_sel1 = 3'd5;
      #1;
      chk("t5_rd5", 32'(rd_data1), 0);
      chk("t5_q_empty", 32'(exp_ch1.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
